// File: rtl/spi_flash_page_program.sv
// spi_flash_page_program: one-shot SPI master that issues WREN and
// then PAGE PROGRAM with an incrementing byte pattern after reset.
module spi_flash_page_program #(
  parameter int unsigned POWERUP_CYCLES = 500000,
  parameter int unsigned CS_GAP_CYCLES  = 10,
  parameter logic [23:0] PAGE_ADDR      = 24'h000000,
  parameter int unsigned BYTE_NUM       = 256,
  parameter logic [7:0]  DATA_START     = 8'h00
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic spi_miso,
  output logic spi_sclk,
  output logic spi_cs,
  output logic spi_mosi
);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_WREN,
    ST_GAP,
    ST_PP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_LEAD,
    PH_SHIFT,
    PH_TAIL
  } phase_t;

  localparam logic [31:0] PU_LAST  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(CS_GAP_CYCLES - 1);
  localparam logic [8:0]  PP_LAST  = 9'(BYTE_NUM + 3);

  state_t      state;
  state_t      state_n;
  phase_t      ph;
  logic [1:0]  q;
  logic [2:0]  bit_idx;
  logic [8:0]  byte_idx;
  logic [31:0] cnt;

  logic        in_frame;
  logic        q_end;
  logic        bit_end;
  logic        byte_end;
  logic        last_byte;
  logic        frame_end;
  logic [8:0]  data_k;
  logic [7:0]  cur_byte;
  logic        cs_d;
  logic        sclk_d;
  logic        mosi_d;

  // The flash data output is never read back.
  logic        unused_miso;
  assign unused_miso = spi_miso;

  assign in_frame  = (state == ST_WREN) || (state == ST_PP);
  assign q_end     = (q == 2'd3);
  assign bit_end   = in_frame && (ph == PH_SHIFT) && q_end;
  assign byte_end  = bit_end && (bit_idx == 3'd7);
  assign last_byte = (state == ST_WREN) ? (byte_idx == 9'd0)
                                        : (byte_idx == PP_LAST);
  assign frame_end = (ph == PH_TAIL) && q_end;
  assign data_k    = byte_idx - 9'd4;

  // Byte currently on the wire: opcode, address, then data pattern.
  always_comb begin
    cur_byte = 8'h00;
    if (state == ST_WREN) begin
      cur_byte = 8'h06;
    end else begin
      unique case (1'b1)
        (byte_idx == 9'd0): cur_byte = 8'h02;
        (byte_idx == 9'd1): cur_byte = PAGE_ADDR[23:16];
        (byte_idx == 9'd2): cur_byte = PAGE_ADDR[15:8];
        (byte_idx == 9'd3): cur_byte = PAGE_ADDR[7:0];
        default:            cur_byte = DATA_START + data_k[7:0];
      endcase
    end
  end

  // Next-state and pin decode; pins are registered below.
  always_comb begin
    state_n = state;
    cs_d    = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    unique case (state)
      ST_POWERUP: begin
        if (cnt == PU_LAST) state_n = ST_WREN;
      end
      ST_WREN: begin
        cs_d   = 1'b0;
        sclk_d = (ph == PH_SHIFT) && q[1];
        mosi_d = (ph == PH_SHIFT) && cur_byte[~bit_idx];
        if (frame_end) state_n = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_n = ST_PP;
      end
      ST_PP: begin
        cs_d   = 1'b0;
        sclk_d = (ph == PH_SHIFT) && q[1];
        mosi_d = (ph == PH_SHIFT) && cur_byte[~bit_idx];
        if (frame_end) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_DONE;
      end
      default: begin
        state_n = ST_POWERUP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_POWERUP;
    else            state <= state_n;
  end

  // Wait counter for power-up and the chip-select gap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state == ST_POWERUP || state == ST_GAP) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Quarter-bit counter, free running inside a frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     q <= 2'd0;
    else if (in_frame)  q <= q + 2'd1;
    else                q <= 2'd0;
  end

  // Frame phase: one idle bit lead-in, shifting, one idle bit tail.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ph <= PH_LEAD;
    end else if (!in_frame) begin
      ph <= PH_LEAD;
    end else if (q_end) begin
      unique case (ph)
        PH_LEAD:  ph <= PH_SHIFT;
        PH_SHIFT: if (byte_end && last_byte) ph <= PH_TAIL;
        PH_TAIL:  ph <= PH_LEAD;
        default:  ph <= PH_LEAD;
      endcase
    end
  end

  // Bit position within the current byte, MSB first.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     bit_idx <= 3'd0;
    else if (!in_frame) bit_idx <= 3'd0;
    else if (bit_end)   bit_idx <= bit_idx + 3'd1;
  end

  // Byte position within the frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     byte_idx <= 9'd0;
    else if (!in_frame) byte_idx <= 9'd0;
    else if (byte_end && !last_byte)
      byte_idx <= byte_idx + 9'd1;
  end

  // Registered SPI pins keep the bus glitch free.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      spi_cs   <= cs_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_page_program.sv
// tb_spi_flash_page_program: decodes the SPI bus and scores frames
// against expected bytes, timing vectors and reset behaviour.
module tb_spi_flash_page_program;

  localparam int          P    = 200;
  localparam int          GAP  = 10;
  localparam logic [23:0] ADDR = 24'h0A5BC3;
  localparam int          NB   = 256;
  localparam logic [7:0]  DS   = 8'hF0;
  localparam int          MAXC = 20000;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic spi_miso;
  logic spi_sclk;
  logic spi_cs;
  logic spi_mosi;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] exp_q[$];
  int         flen_q[$];

  spi_flash_page_program #(
    .POWERUP_CYCLES(P),
    .CS_GAP_CYCLES(GAP),
    .PAGE_ADDR(ADDR),
    .BYTE_NUM(NB),
    .DATA_START(DS)
  ) u_dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .spi_miso(spi_miso),
    .spi_sclk(spi_sclk),
    .spi_cs(spi_cs),
    .spi_mosi(spi_mosi)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    n_cmp++;
    if (act < lim) begin
      n_bad++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
    end
  endtask

  task automatic fill_expect();
    logic [7:0] b;
    exp_q.delete();
    flen_q.delete();
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h02);
    exp_q.push_back(ADDR[23:16]);
    exp_q.push_back(ADDR[15:8]);
    exp_q.push_back(ADDR[7:0]);
    b = DS;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(b);
      b = b + 8'd1;
    end
    flen_q.push_back(8);
    flen_q.push_back((4 + NB) * 8);
  endtask

  task automatic run_seq(input bit chk_vec, input int abort_at);
    int   cyc, nfall, bits, nbytes, gap, hi, last_rise;
    int   pu_bad, cs_bad, hi_min, hi_max, per_min, per_max, d;
    logic p_cs, p_sclk;
    logic [7:0] sh, eb;
    bit   done;
    cyc = 0; nfall = 0; bits = 0; nbytes = 0; gap = 0; hi = 0;
    last_rise = -1; pu_bad = 0; cs_bad = 0;
    hi_min = 1000; hi_max = 0; per_min = 1000; per_max = 0;
    p_cs = 1'b1; p_sclk = 1'b0; sh = 8'h00; done = 1'b0;
    while (!done && cyc < MAXC) begin
      @(negedge sys_clk);
      cyc++;
      if (chk_vec) begin
        foreach (vecs[i]) begin
          if (vecs[i].cyc == cyc)
            chk($sformatf("pins@%0d", cyc),
                int'({spi_cs, spi_sclk, spi_mosi}),
                int'(vecs[i].exp));
        end
      end
      if (cyc <= P && {spi_cs, spi_sclk, spi_mosi} != 3'b100)
        pu_bad++;
      if (spi_cs && (spi_sclk || spi_mosi))
        cs_bad++;
      if (p_cs && !spi_cs) begin
        nfall++;
        bits = 0;
        last_rise = -1;
        if (nfall > 1) chk_ge("cs_gap", gap, GAP);
      end
      if (!spi_cs && !p_sclk && spi_sclk) begin
        sh = {sh[6:0], spi_mosi};
        bits++;
        if (last_rise >= 0) begin
          d = cyc - last_rise;
          if (d < per_min) per_min = d;
          if (d > per_max) per_max = d;
        end
        last_rise = cyc;
        if (bits % 8 == 0) begin
          nbytes++;
          if (exp_q.size() == 0) begin
            chk("byte_extra", int'(sh), -1);
          end else begin
            eb = exp_q.pop_front();
            chk($sformatf("byte%0d", nbytes - 1), int'(sh), int'(eb));
          end
        end
      end
      if (spi_sclk) begin
        hi++;
      end else if (p_sclk) begin
        if (hi < hi_min) hi_min = hi;
        if (hi > hi_max) hi_max = hi;
        hi = 0;
      end
      if (!p_cs && spi_cs) begin
        if (flen_q.size() == 0) chk("frame_extra", bits, -1);
        else chk("frame_bits", bits, flen_q.pop_front());
        gap = 0;
      end
      if (spi_cs) gap++;
      if (abort_at > 0 && nbytes >= abort_at && spi_sclk)
        done = 1'b1;
      if (abort_at == 0 && nfall == 2 && spi_cs && gap >= 300)
        done = 1'b1;
      p_cs = spi_cs;
      p_sclk = spi_sclk;
    end
    chk("run_timeout", int'(done), 1);
    if (abort_at == 0) begin
      chk("cs_falls", nfall, 2);
      chk("bytes_left", exp_q.size(), 0);
      chk("frames_left", flen_q.size(), 0);
      chk("powerup_idle", pu_bad, 0);
      chk("idle_bus_quiet", cs_bad, 0);
      chk("sclk_hi_min", hi_min, 2);
      chk("sclk_hi_max", hi_max, 2);
      chk("sclk_per_min", per_min, 4);
      chk("sclk_per_max", per_max, 4);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    spi_miso  = 1'b0;
    vecs[0]  = '{1,      3'b100};
    vecs[1]  = '{P / 2,  3'b100};
    vecs[2]  = '{P,      3'b100};
    vecs[3]  = '{P + 1,  3'b000};
    vecs[4]  = '{P + 4,  3'b000};
    vecs[5]  = '{P + 5,  3'b000};
    vecs[6]  = '{P + 7,  3'b010};
    vecs[7]  = '{P + 25, 3'b001};
    vecs[8]  = '{P + 27, 3'b011};
    vecs[9]  = '{P + 40, 3'b000};
    vecs[10] = '{P + 41, 3'b100};
    vecs[11] = '{P + 50, 3'b100};
    vecs[12] = '{P + 51, 3'b000};

    repeat (2) @(negedge sys_clk);
    chk("rst_cs", int'(spi_cs), 1);
    chk("rst_sclk", int'(spi_sclk), 0);
    chk("rst_mosi", int'(spi_mosi), 0);

    fill_expect();
    sys_rst_n = 1'b1;
    run_seq(1'b1, 0);

    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    fill_expect();
    run_seq(1'b0, 5 + 100);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("midrst_cs", int'(spi_cs), 1);
    chk("midrst_sclk", int'(spi_sclk), 0);
    chk("midrst_mosi", int'(spi_mosi), 0);
    repeat (3) @(negedge sys_clk);
    chk("midrst_hold_cs", int'(spi_cs), 1);

    fill_expect();
    sys_rst_n = 1'b1;
    run_seq(1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
